store_write_buffer: RTL and testbench

//  Memory-stage store path: decodes sb/sh/sw, builds lane-aligned write data and byte enables,
//  and queues stores in a small FIFO drained to data memory/bridge over a req/ack handshake.
//  It is the write-side counterpart of the WB load extractor: that block narrows a word into GRF

---
 rtl/store_write_buffer_pkg.sv | 17 +
 rtl/store_write_buffer_if.sv | 11 +
 rtl/store_write_buffer_lane_encoder.sv | 38 +++
 rtl/store_write_buffer.sv | 101 ++++++++++
 tb/tb_store_write_buffer.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/store_write_buffer_pkg.sv
// Shared store-path definitions: opcode prefix, access-size encoding and entry payload.
package store_write_buffer_pkg;

  localparam logic [2:0] STORE_OP = 3'b101;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_NONE = 2'b10,
    SIZE_WORD = 2'b11
  } size_e;

  function automatic logic is_store_op(input logic [31:0] inst);
    return inst[31:29] == STORE_OP;
  endfunction

endpackage

// File: rtl/store_write_buffer_if.sv
// Data-bus write channel: head-of-FIFO store presented with req/ack handshake.
interface store_write_buffer_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_byteen;
  logic        mem_ack;

  modport master (output mem_req, mem_addr, mem_wdata, mem_byteen, input mem_ack);
  modport slave  (input mem_req, mem_addr, mem_wdata, mem_byteen, output mem_ack);
endinterface

// File: rtl/store_write_buffer_lane_encoder.sv
// Widens a register value into lane-replicated write data with byte enables for sb/sh/sw.
module store_lane_encoder
  import store_write_buffer_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  lane,
  input  logic [31:0] rt,
  output logic [3:0]  byteen,
  output logic [31:0] wdata,
  output logic        misaligned,
  output logic        size_ok
);

  always_comb begin
    byteen     = '0;
    wdata      = '0;
    misaligned = 1'b0;
    size_ok    = 1'b1;
    case (size_e'(size))
      SIZE_BYTE: begin
        byteen = 4'b0001 << lane;
        wdata  = {4{rt[7:0]}};
      end
      SIZE_HALF: begin
        byteen     = lane[1] ? 4'b1100 : 4'b0011;
        wdata      = {2{rt[15:0]}};
        misaligned = lane[0];
      end
      SIZE_WORD: begin
        byteen     = '1;
        wdata      = rt;
        misaligned = (lane != 2'b00);
      end
      default: size_ok = 1'b0;
    endcase
  end

endmodule

// File: rtl/store_write_buffer.sv
// MEM-stage store buffer: decodes stores, queues masked word writes, drains over req/ack.
module store_write_buffer
  import store_write_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Inst,
  input  logic        inst_valid,
  input  logic [31:0] AO,
  input  logic [31:0] RT,
  output logic        store_stall,
  output logic        addr_error,
  input  logic        load_check_valid,
  input  logic [31:0] load_check_addr,
  output logic        load_hazard,
  store_write_buffer_if.master bus
);

  localparam int unsigned PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW:0] FULL = (PW + 1)'(DEPTH);

  logic [29:0] ent_addr   [DEPTH];
  logic [31:0] ent_data   [DEPTH];
  logic [3:0]  ent_byteen [DEPTH];

  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [PW:0]   count;

  logic [3:0]  enc_byteen;
  logic [31:0] enc_wdata;
  logic        enc_misaligned, enc_size_ok;
  logic        is_store, aligned_store, accept, push, pop;

  store_lane_encoder u_enc (
    .size       (Inst[27:26]),
    .lane       (AO[1:0]),
    .rt         (RT),
    .byteen     (enc_byteen),
    .wdata      (enc_wdata),
    .misaligned (enc_misaligned),
    .size_ok    (enc_size_ok)
  );

  assign is_store      = inst_valid & is_store_op(Inst) & enc_size_ok;
  assign addr_error    = is_store & enc_misaligned;
  assign aligned_store = is_store & ~enc_misaligned;

  // Bus side is driven purely from state so mem_req never depends on this cycle's inputs.
  assign bus.mem_req    = (count != '0);
  assign bus.mem_addr   = {ent_addr[rd_ptr], 2'b00};
  assign bus.mem_wdata  = ent_data[rd_ptr];
  assign bus.mem_byteen = ent_byteen[rd_ptr];

  assign pop         = bus.mem_req & bus.mem_ack;
  assign accept      = (count < FULL) | pop;
  assign push        = aligned_store & accept;
  assign store_stall = aligned_store & ~accept;

  // An entry is live when its distance from the read pointer is below the occupancy.
  always_comb begin
    logic [PW-1:0] off;
    load_hazard = 1'b0;
    off         = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      off = PW'(i) - rd_ptr;
      if (load_check_valid && ({1'b0, off} < count) &&
          (ent_addr[i] == load_check_addr[31:2]))
        load_hazard = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        ent_addr[i]   <= '0;
        ent_data[i]   <= '0;
        ent_byteen[i] <= '0;
      end
    end else begin
      if (push) begin
        ent_addr[wr_ptr]   <= AO[31:2];
        ent_data[wr_ptr]   <= enc_wdata;
        ent_byteen[wr_ptr] <= enc_byteen;
        wr_ptr             <= wr_ptr + 1'b1;
      end
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_store_write_buffer.sv
// Scoreboard bench: driver predicts store acceptance and queues expected bus writes; monitor drains them.
module tb_store_write_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Inst, AO, RT, load_check_addr;
  logic        inst_valid, load_check_valid;
  logic        store_stall, addr_error, load_hazard;

  store_write_buffer_if bus ();

  store_write_buffer #(.DEPTH(2)) dut (
    .clk              (clk),
    .reset            (reset),
    .Inst             (Inst),
    .inst_valid       (inst_valid),
    .AO               (AO),
    .RT               (RT),
    .store_stall      (store_stall),
    .addr_error       (addr_error),
    .load_check_valid (load_check_valid),
    .load_check_addr  (load_check_addr),
    .load_hazard      (load_hazard),
    .bus              (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } txn_t;

  localparam int MODEL_DEPTH = 2;
  localparam logic [31:0] I_SB = 32'hA000_0000;
  localparam logic [31:0] I_SH = 32'hA400_0000;
  localparam logic [31:0] I_SW = 32'hAC00_0000;

  txn_t sb[$];
  txn_t pend;
  bit   have_pend = 1'b0;
  bit   in_reset  = 1'b1;
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference lane model written from the arithmetic of each access size.
  function automatic void model_store(input logic [31:0] inst, input logic [31:0] ao,
                                      input logic [31:0] rt, output bit is_st,
                                      output bit mis, output txn_t t);
    logic [1:0] size;
    size   = inst[27:26];
    is_st  = (inst[31:29] == 3'b101) && (size != 2'b10);
    mis    = 1'b0;
    t.addr = ao & ~32'h3;
    t.data = '0;
    t.be   = '0;
    case (size)
      2'b00: begin
        t.be   = 4'(1 << ao[1:0]);
        t.data = {24'h0, rt[7:0]} * 32'h0101_0101;
      end
      2'b01: begin
        t.be   = ao[1] ? 4'hC : 4'h3;
        t.data = {16'h0, rt[15:0]} * 32'h0001_0001;
        mis    = ao[0];
      end
      2'b11: begin
        t.be   = 4'hF;
        t.data = rt;
        mis    = (ao[1:0] != 2'b00);
      end
      default: ;
    endcase
  endfunction

  task automatic cycle(input bit iv, input logic [31:0] inst, input logic [31:0] ao,
                       input logic [31:0] rt, input bit lcv, input logic [31:0] lca,
                       input bit ack, output bit stalled);
    bit   is_st, mis, pop_now, accept, exp_hz;
    txn_t t;
    @(posedge clk);
    #1;
    if (have_pend) begin
      sb.push_back(pend);
      have_pend = 1'b0;
    end
    inst_valid       = iv;
    Inst             = inst;
    AO               = ao;
    RT               = rt;
    load_check_valid = lcv;
    load_check_addr  = lca;
    bus.mem_ack      = ack;
    #2;
    model_store(inst, ao, rt, is_st, mis, t);
    is_st   = is_st && iv;
    pop_now = ack && (sb.size() != 0);
    accept  = (sb.size() < MODEL_DEPTH) || pop_now;
    exp_hz  = 1'b0;
    if (lcv)
      foreach (sb[k]) if (sb[k].addr[31:2] == lca[31:2]) exp_hz = 1'b1;
    check("addr_error", {31'h0, addr_error}, {31'h0, is_st && mis});
    check("store_stall", {31'h0, store_stall}, {31'h0, is_st && !mis && !accept});
    check("load_hazard", {31'h0, load_hazard}, {31'h0, exp_hz});
    stalled = is_st && !mis && !accept;
    if (is_st && !mis && accept) begin
      pend      = t;
      have_pend = 1'b1;
    end
  endtask

  task automatic idle(input bit ack, input int n);
    bit s;
    for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, '0, 1'b0, '0, ack, s);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    have_pend        = 1'b0;
    in_reset         = 1'b1;
    reset            = 1'b1;
    inst_valid       = 1'b0;
    load_check_valid = 1'b0;
    bus.mem_ack      = 1'b0;
    sb.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    #2;
    check("rst_mem_req", {31'h0, bus.mem_req}, 32'h0);
    check("rst_mem_addr", bus.mem_addr, 32'h0);
    check("rst_mem_wdata", bus.mem_wdata, 32'h0);
    check("rst_mem_byteen", {28'h0, bus.mem_byteen}, 32'h0);
    check("rst_flags", {29'h0, store_stall, addr_error, load_hazard}, 32'h0);
    in_reset = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!in_reset) begin
      check("mem_req", {31'h0, bus.mem_req}, {31'h0, sb.size() != 0});
      if (bus.mem_req && sb.size() != 0) begin
        check("mem_addr", bus.mem_addr, sb[0].addr);
        check("mem_wdata", bus.mem_wdata, sb[0].data);
        check("mem_byteen", {28'h0, bus.mem_byteen}, {28'h0, sb[0].be});
        if (bus.mem_ack) void'(sb.pop_front());
      end
    end
  end

  initial begin
    bit          s;
    logic [31:0] inst, ao, rt, lca;
    bit          lcv;
    reset = 1'b1; inst_valid = 1'b0; Inst = '0; AO = '0; RT = '0;
    load_check_valid = 1'b0; load_check_addr = '0; bus.mem_ack = 1'b0;
    do_reset();

    cycle(1'b1, I_SW, 32'h104, 32'h1234_5678, 1'b0, '0, 1'b1, s);
    idle(1'b1, 2);
    cycle(1'b1, I_SB, 32'h203, 32'h0000_00AB, 1'b0, '0, 1'b1, s);
    cycle(1'b1, I_SH, 32'h202, 32'h0000_BEEF, 1'b0, '0, 1'b1, s);
    idle(1'b1, 2);
    cycle(1'b1, I_SH, 32'h101, 32'h0000_1111, 1'b0, '0, 1'b0, s);
    cycle(1'b1, I_SW, 32'h102, 32'h0000_2222, 1'b0, '0, 1'b0, s);
    idle(1'b0, 1);

    cycle(1'b1, I_SW, 32'h400, 32'hAAAA_0001, 1'b0, '0, 1'b0, s);
    cycle(1'b1, I_SW, 32'h404, 32'hAAAA_0002, 1'b0, '0, 1'b0, s);
    cycle(1'b1, I_SW, 32'h408, 32'hAAAA_0003, 1'b0, '0, 1'b0, s);
    cycle(1'b1, I_SW, 32'h408, 32'hAAAA_0003, 1'b0, '0, 1'b0, s);
    cycle(1'b1, I_SW, 32'h408, 32'hAAAA_0003, 1'b0, '0, 1'b1, s);
    idle(1'b1, 3);

    cycle(1'b1, I_SW, 32'h300, 32'h5555_5555, 1'b0, '0, 1'b0, s);
    cycle(1'b0, '0, '0, '0, 1'b1, 32'h302, 1'b0, s);
    cycle(1'b0, '0, '0, '0, 1'b1, 32'h302, 1'b1, s);
    cycle(1'b0, '0, '0, '0, 1'b1, 32'h302, 1'b0, s);
    cycle(1'b0, '0, '0, '0, 1'b1, 32'h304, 1'b0, s);

    cycle(1'b1, I_SW, 32'h500, 32'h0000_0001, 1'b0, '0, 1'b0, s);
    cycle(1'b1, I_SB, 32'h505, 32'h0000_0002, 1'b0, '0, 1'b0, s);
    idle(1'b0, 1);
    do_reset();
    cycle(1'b1, I_SW, 32'h600, 32'hCAFE_F00D, 1'b0, '0, 1'b1, s);
    idle(1'b1, 2);

    s = 1'b0;
    inst = '0; ao = '0; rt = '0;
    for (int i = 0; i < 600; i++) begin
      if (!s) begin
        inst = $urandom;
        if ($urandom_range(0, 3) != 0) inst[31:29] = 3'b101;
        ao = 32'h100 + ($urandom_range(0, 7) << 2) + $urandom_range(0, 3);
        rt = $urandom;
      end
      lcv = ($urandom_range(0, 1) == 1);
      lca = 32'h100 + ($urandom_range(0, 7) << 2) + $urandom_range(0, 3);
      cycle(($urandom_range(0, 4) != 0) || s, inst, ao, rt, lcv, lca,
            ($urandom_range(0, 2) != 0), s);
    end

    for (int i = 0; i < 10 && (sb.size() != 0 || have_pend); i++) idle(1'b1, 1);
    check("drain_empty", sb.size(), 32'h0);
    idle(1'b0, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
